// File: rtl/lsu_pkg.sv
// lsu_pkg: shared FSM state encoding, RV32I funct3 constants and byte-enable helper for the load/store unit
package lsu_pkg;
  typedef enum logic [2:0] {IDLE, ACC0, ACC1, CAP, RESP} lsu_state_t;
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  // Byte enables across two adjacent words; bits [7:4] are the lanes of the following word
  function automatic logic [7:0] be_gen(input logic [1:0] sz, input logic [1:0] off);
    return (sz == 2'd0 ? 8'h01 : sz == 2'd1 ? 8'h03 : 8'h0F) << off;
  endfunction
endpackage

// File: rtl/lsu_load_format.sv
// lsu_load_format: selects the addressed byte/half/word from merged load data and sign/zero-extends it
module lsu_load_format
  import lsu_pkg::*;
(
  input  logic [63:0] data,
  input  logic [1:0]  off,
  input  logic [2:0]  f3,
  output logic [31:0] dout
);
  logic [31:0] sel;
  // Shift the addressed byte to lane 0, then extend according to funct3
  always_comb begin
    sel = 32'(data >> {off, 3'b000});
    dout = f3 == F3_B  ? {{24{sel[7]}}, sel[7:0]} :
           f3 == F3_H  ? {{16{sel[15]}}, sel[15:0]} :
           f3 == F3_W  ? sel :
           f3 == F3_BU ? {24'h0, sel[7:0]} :
           f3 == F3_HU ? {16'h0, sel[15:0]} : 32'h0;
  end
endmodule

// File: rtl/lsu_mem_stage.sv
// lsu_mem_stage: RV32I load/store unit for a 4-lane word-indexed data memory; define LSU_MISALIGN_SPLIT_EN to split misaligned accesses
module lsu_mem_stage
  import lsu_pkg::*;
#(
  parameter int DEPTH_WORDS = 512,
  parameter int IDX_W = $clog2(DEPTH_WORDS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_store,
  input  logic [2:0]       req_funct3,
  input  logic [31:0]      req_addr,
  input  logic [31:0]      req_wdata,
  input  logic [4:0]       req_rd,
  output logic             mem_re,
  output logic             mem_we,
  output logic [3:0]       mem_be,
  output logic [IDX_W-1:0] mem_idx,
  output logic [31:0]      mem_wdata,
  input  logic [31:0]      mem_rdata,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_data,
  output logic [4:0]       rsp_rd,
  output logic             rsp_err
);
  lsu_state_t state_q, state_d;
  logic store_q, store_d, rsp_err_q, rsp_err_d;
  logic [2:0] f3_q, f3_d, sz_m1;
  logic [1:0] off_q, off_d;
  logic [IDX_W-1:0] idx_q, idx_d, lane_idx;
  logic [31:0] wdata_q, wdata_d, rsp_data_q, rsp_data_d, fmt, lane_wd;
  logic [4:0] rsp_rd_q, rsp_rd_d;
  logic [32:0] last;
  logic [3:0] lane_be;
  logic [63:0] merged;
  logic bad_f3, oor, acc_err, acc, hi_sel;
`ifdef LSU_MISALIGN_SPLIT_EN
  logic split_q, split_d, cross;
  logic [31:0] lo_q, lo_d;
  logic [63:0] wsh;
  logic [7:0] be8;
`endif
  // Decode size, funct3 legality and whether the last byte touched lies past the memory
  always_comb begin
    sz_m1 = req_funct3[1:0] == 2'd0 ? 3'd0 : req_funct3[1:0] == 2'd1 ? 3'd1 : 3'd3;
    bad_f3 = req_store ? req_funct3 > F3_W : (req_funct3 == 3'b011 || req_funct3[2:1] == 2'b11);
    last = {1'b0, req_addr} + {30'd0, sz_m1};
    oor = last >= 33'(4 * DEPTH_WORDS);
`ifdef LSU_MISALIGN_SPLIT_EN
    cross = {1'b0, req_addr[1:0]} + sz_m1 > 3'd3;
    acc_err = bad_f3 || oor;
`else
    acc_err = bad_f3 || oor || (req_addr[1:0] & sz_m1[1:0]) != 2'd0;
`endif
  end
`ifdef LSU_MISALIGN_SPLIT_EN
  assign wsh = {32'h0, wdata_q} << {off_q, 3'b000};
  assign be8 = be_gen(f3_q[1:0], off_q);
  assign hi_sel = state_q == ACC1;
  assign lane_be = hi_sel ? be8[7:4] : be8[3:0];
  assign lane_wd = hi_sel ? wsh[63:32] : wsh[31:0];
  assign lane_idx = idx_q + IDX_W'(hi_sel);
  assign merged = split_q ? {mem_rdata, lo_q} : {32'h0, mem_rdata};
`else
  assign hi_sel = 1'b0;
  assign lane_be = 4'(be_gen(f3_q[1:0], off_q));
  assign lane_wd = wdata_q << {off_q, 3'b000};
  assign lane_idx = idx_q;
  assign merged = {32'h0, mem_rdata};
`endif
  lsu_load_format u_fmt (
    .data(merged),
    .off (off_q),
    .f3  (f3_q),
    .dout(fmt)
  );
  // Next state and request/response register updates
  always_comb begin
    state_d = state_q;
    store_d = store_q;
    f3_d = f3_q;
    off_d = off_q;
    idx_d = idx_q;
    wdata_d = wdata_q;
    rsp_data_d = rsp_data_q;
    rsp_rd_d = rsp_rd_q;
    rsp_err_d = rsp_err_q;
`ifdef LSU_MISALIGN_SPLIT_EN
    split_d = split_q;
    lo_d = lo_q;
`endif
    case (state_q)
      IDLE: if (req_valid) begin
        state_d = acc_err ? RESP : ACC0;
        store_d = req_store;
        f3_d = req_funct3;
        off_d = req_addr[1:0];
        idx_d = req_addr[IDX_W+1:2];
        wdata_d = req_wdata;
        rsp_rd_d = req_rd;
        rsp_err_d = acc_err;
        rsp_data_d = '0;
`ifdef LSU_MISALIGN_SPLIT_EN
        split_d = cross;
`endif
      end
`ifdef LSU_MISALIGN_SPLIT_EN
      ACC0: state_d = split_q ? ACC1 : store_q ? RESP : CAP;
      ACC1: begin
        state_d = store_q ? RESP : CAP;
        lo_d = mem_rdata;
      end
`else
      ACC0: state_d = store_q ? RESP : CAP;
`endif
      CAP: begin
        state_d = RESP;
        rsp_data_d = fmt;
      end
      RESP: state_d = rsp_ready ? IDLE : RESP;
      default: state_d = IDLE;
    endcase
  end
  // Registers; reset discards any in-flight access
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      store_q <= 1'b0;
      f3_q <= '0;
      off_q <= '0;
      idx_q <= '0;
      wdata_q <= '0;
      rsp_data_q <= '0;
      rsp_rd_q <= '0;
      rsp_err_q <= 1'b0;
`ifdef LSU_MISALIGN_SPLIT_EN
      split_q <= 1'b0;
      lo_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      store_q <= store_d;
      f3_q <= f3_d;
      off_q <= off_d;
      idx_q <= idx_d;
      wdata_q <= wdata_d;
      rsp_data_q <= rsp_data_d;
      rsp_rd_q <= rsp_rd_d;
      rsp_err_q <= rsp_err_d;
`ifdef LSU_MISALIGN_SPLIT_EN
      split_q <= split_d;
      lo_q <= lo_d;
`endif
    end
  end
  assign acc = !rst && (state_q == ACC0 || hi_sel);
  assign req_ready = !rst && state_q == IDLE;
  assign mem_re = acc && !store_q;
  assign mem_we = acc && store_q;
  assign mem_be = acc ? lane_be : '0;
  assign mem_idx = acc ? lane_idx : '0;
  assign mem_wdata = mem_we ? lane_wd : '0;
  assign rsp_valid = !rst && state_q == RESP;
  assign rsp_data = rst ? '0 : rsp_data_q;
  assign rsp_rd = rst ? '0 : rsp_rd_q;
  assign rsp_err = !rst && rsp_err_q;
endmodule
